fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction-buffer depth in entries (power of two, >=2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the fetch address loaded on reset.
REQ-003 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 imem_req  out  1  fetch request to instruction memory; SHALL be held until acked.
REQ-006 imem_addr  out  32  word-aligned fetch address; SHALL be stable while imem_req=1.
REQ-007 imem_ack  in  1  memory has returned imem_rdata this cycle; SHALL be ignored when imem_req=0.
REQ-008 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-009 out_valid  out  1  buffer head holds an instruction for decode.
REQ-010 out_inst  out  32  head instruction word.
REQ-011 out_pc  out  32  address of the head instruction.
REQ-012 out_ready  in  1  decode accepts the head; pop occurs when out_valid & out_ready.
REQ-013 redirect  in  1  jump/branch/JR taken; flush and refetch.
REQ-014 redirect_pc  in  32  new fetch address; bits [1:0] SHALL be forced to 00.
REQ-015 halted  out  1  halt word fetched and buffer drained.

Function
REQ-016 The FSM SHALL have four states: IDLE (no request), REQ (imem_req=1, data kept), DRAIN (imem_req=1, data discarded), HALT (no request).
REQ-017 At most one request SHALL be outstanding; imem_addr SHALL equal fetch_pc in REQ and the stale address in DRAIN.
REQ-018 A request is accepted in the cycle imem_ack=1 while imem_req=1; zero-wait (ack in first req cycle) SHALL be supported.
REQ-019 REQ + ack, no redirect: push {fetch_pc, imem_rdata}; fetch_pc <= fetch_pc+4 (mod 2^32, wrap from FFFF_FFFC to 0).
REQ-020 After the push, the next state SHALL be REQ if count_next < DEPTH, else IDLE; count_next counts this cycle's push and pop.
REQ-021 IDLE SHALL go to REQ in the first cycle where count_next < DEPTH; the buffer SHALL never overflow.
REQ-022 If the pushed word equals 32'h0000_0000, the next state SHALL be HALT and no further requests SHALL issue; the zero word is still delivered to decode.
REQ-023 halted SHALL be 1 iff state=HALT and count=0.
REQ-024 Pushed data SHALL appear on out_* in the cycle after the ack (1-cycle fetch-to-decode latency when empty).
REQ-025 out_valid = (count != 0); out_inst/out_pc SHALL be the oldest entry; each pop advances the head by one.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged.
REQ-027 redirect=1 SHALL, in all states: empty the buffer (count <= 0; any same-cycle push/pop void) and set fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-028 Redirect state transition: REQ without ack -> DRAIN; REQ with ack, IDLE, HALT, DRAIN with ack -> REQ; DRAIN without ack -> DRAIN.
REQ-029 DRAIN + ack, no redirect: discard imem_rdata; next state REQ at the current fetch_pc.
REQ-030 redirect SHALL have priority over halt detection; a zero word arriving with redirect SHALL NOT enter HALT.
REQ-031 out_valid SHALL never be asserted for an entry fetched before a redirect.

Reset
REQ-032 rst=1 SHALL set fetch_pc=RESET_PC, count=0, head/tail pointers=0, and state=REQ; an outstanding request SHALL be abandoned.
REQ-033 During rst, imem_req=0, out_valid=0, and halted=0; in the first cycle after rst falls, imem_req=1 and imem_addr=RESET_PC.
REQ-034 rst SHALL override redirect and imem_ack in the same cycle.

Verification
REQ-035 Zero-wait stream, out_ready=1, words 1,2,3: out_pc 0,4,8 one per cycle, each 1 cycle after its ack, no bubbles.
REQ-036 out_ready=0, DEPTH=4, zero-wait memory: exactly 4 acks, then imem_req=0 (IDLE); one pop -> imem_req=1 next cycle with addr 0x10.
REQ-037 Redirect to 0x103 while REQ waits for a 3-cycle ack: state DRAIN; returned word discarded; next request at 0x100; first out_pc=0x100.
REQ-038 Memory returns 0 at 0x8: no request after that ack; the zero word is delivered at out_pc=0x8; halted=1 once the buffer empties; redirect to 0x40 clears halted and fetches 0x40.
REQ-039 Redirect in the same cycle as a push and a pop with 2 entries: count=0 next cycle; out_valid=0; no stale out_pc later emitted.
REQ-040 rst asserted mid-DRAIN with a late ack pending: after release, imem_addr=RESET_PC, count=0, and the late ack is ignored while imem_req=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small
// in-order instruction buffer, with redirect flush and halt-on-zero-word.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemAck,
    input  logic [31:0] i_imemRdata,
    output logic        o_outValid,
    output logic [31:0] o_outInst,
    output logic [31:0] o_outPc,
    input  logic        i_outReady,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectPc,
    output logic        o_halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [31:0]    r_fetchPc;
    logic [31:0]    r_drainAddr;
    logic [CW-1:0]  r_count;
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [31:0]    r_instMem [DEPTH];
    logic [31:0]    r_pcMem   [DEPTH];

    logic           w_reqActive;
    logic           w_ack;
    logic           w_push;
    logic           w_pop;
    logic [CW-1:0]  w_countNext;
    logic           w_room;
    logic [31:0]    w_redirectPc;

    assign w_reqActive  = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign w_ack        = w_reqActive && i_imemAck;
    assign w_push       = (r_state == S_REQ) && i_imemAck && !i_redirect;
    assign w_pop        = (r_count != '0) && i_outReady && !i_redirect;
    assign w_countNext  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_room       = w_countNext < CW'(DEPTH);
    assign w_redirectPc = i_redirectPc & ~32'h0000_0003;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Redirect outranks everything, including halt detection on a zero word.
    always_comb begin
        w_stateNext = r_state;
        if (i_redirect) begin
            if (w_reqActive && !w_ack) begin
                w_stateNext = S_DRAIN;
            end else begin
                w_stateNext = S_REQ;
            end
        end else begin
            case (r_state)
                S_IDLE:  w_stateNext = w_room ? S_REQ : S_IDLE;
                S_REQ: begin
                    if (w_ack) begin
                        if (i_imemRdata == 32'h0000_0000) begin
                            w_stateNext = S_HALT;
                        end else begin
                            w_stateNext = w_room ? S_REQ : S_IDLE;
                        end
                    end
                end
                S_DRAIN: w_stateNext = w_ack ? S_REQ : S_DRAIN;
                S_HALT:  w_stateNext = S_HALT;
                default: w_stateNext = S_REQ;
            endcase
        end
    end

    always_comb begin
        o_imemReq  = !rst && w_reqActive;
        o_imemAddr = (r_state == S_DRAIN) ? r_drainAddr : r_fetchPc;
        o_outValid = !rst && (r_count != '0);
        o_outInst  = r_instMem[r_head];
        o_outPc    = r_pcMem[r_head];
        o_halted   = !rst && (r_state == S_HALT) && (r_count == '0);
    end

    // A request abandoned by redirect keeps its address on the bus until acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchPc   <= RESET_PC;
            r_drainAddr <= RESET_PC;
            r_count     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
        end else if (i_redirect) begin
            r_fetchPc <= w_redirectPc;
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            if ((r_state == S_REQ) && !w_ack) begin
                r_drainAddr <= r_fetchPc;
            end
        end else begin
            if (w_push) begin
                r_fetchPc <= r_fetchPc + 32'd4;
                r_tail    <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= w_countNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_instMem[r_tail] <= i_imemRdata;
            r_pcMem[r_tail]   <= r_fetchPc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: streaming, back-pressure, halt,
// redirect/drain and reset-over-late-ack sequences.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        o_imemReq;
    logic [31:0] o_imemAddr;
    logic        i_imemAck;
    logic [31:0] i_imemRdata;
    logic        o_outValid;
    logic [31:0] o_outInst;
    logic [31:0] o_outPc;
    logic        i_outReady;
    logic        i_redirect;
    logic [31:0] i_redirectPc;
    logic        o_halted;

    int passCount  = 0;
    int totalCount = 0;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInst;
        logic [31:0] ePc;
        logic        eHalted;
    } vec_t;

    vec_t vecs [27];

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .o_imemReq   (o_imemReq),
        .o_imemAddr  (o_imemAddr),
        .i_imemAck   (i_imemAck),
        .i_imemRdata (i_imemRdata),
        .o_outValid  (o_outValid),
        .o_outInst   (o_outInst),
        .o_outPc     (o_outPc),
        .i_outReady  (i_outReady),
        .i_redirect  (i_redirect),
        .i_redirectPc(i_redirectPc),
        .o_halted    (o_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t v(
        input logic rs, input logic ak, input logic [31:0] rd, input logic ry,
        input logic rr, input logic [31:0] rp, input logic eq, input logic [31:0] ea,
        input logic ev, input logic [31:0] ei, input logic [31:0] ep, input logic eh);
        vec_t x;
        x.rst = rs;  x.ack = ak;    x.rdata = rd; x.rdy = ry;
        x.redir = rr; x.rpc = rp;   x.eReq = eq;  x.eAddr = ea;
        x.eValid = ev; x.eInst = ei; x.ePc = ep;  x.eHalted = eh;
        return x;
    endfunction

    task automatic checkOutput(input string name, input int step,
                               input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s step %0d: got %h, want %h", name, step, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are judged 1ns later.
    task automatic applyStimulus(input vec_t x);
        @(negedge clk);
        rst          = x.rst;
        i_imemAck    = x.ack;
        i_imemRdata  = x.rdata;
        i_outReady   = x.rdy;
        i_redirect   = x.redir;
        i_redirectPc = x.rpc;
        #1;
    endtask

    task automatic runVec(input vec_t x, input int step);
        applyStimulus(x);
        checkOutput("imem_req", step, {31'd0, o_imemReq}, {31'd0, x.eReq});
        checkOutput("out_valid", step, {31'd0, o_outValid}, {31'd0, x.eValid});
        checkOutput("halted", step, {31'd0, o_halted}, {31'd0, x.eHalted});
        if (x.eReq) checkOutput("imem_addr", step, o_imemAddr, x.eAddr);
        if (x.eValid) begin
            checkOutput("out_inst", step, o_outInst, x.eInst);
            checkOutput("out_pc", step, o_outPc, x.ePc);
        end
    endtask

    task automatic doReset(input int step);
        runVec(v(1,0,0,0,0,0, 0,0,0,0,0,0), step);
        runVec(v(1,0,0,0,0,0, 0,0,0,0,0,0), step + 1);
    endtask

    initial begin
        rst = 1'b1; i_imemAck = 1'b0; i_imemRdata = '0;
        i_outReady = 1'b0; i_redirect = 1'b0; i_redirectPc = '0;

        vecs[0]  = v(1,0,32'h0,0,0,0,        0,32'h00,0,32'h0,32'h0,0);
        vecs[1]  = v(1,0,32'h0,0,0,0,        0,32'h00,0,32'h0,32'h0,0);
        vecs[2]  = v(0,1,32'h1,1,0,0,        1,32'h00,0,32'h0,32'h0,0);
        vecs[3]  = v(0,1,32'h2,1,0,0,        1,32'h04,1,32'h1,32'h0,0);
        vecs[4]  = v(0,1,32'h3,1,0,0,        1,32'h08,1,32'h2,32'h4,0);
        vecs[5]  = v(0,0,32'h0,1,0,0,        1,32'h0C,1,32'h3,32'h8,0);
        vecs[6]  = v(0,0,32'h0,0,0,0,        1,32'h0C,0,32'h0,32'h0,0);
        vecs[7]  = v(0,1,32'h11,0,0,0,       1,32'h0C,0,32'h0,32'h0,0);
        vecs[8]  = v(0,1,32'h12,0,0,0,       1,32'h10,1,32'h11,32'h0C,0);
        vecs[9]  = v(0,1,32'h13,0,0,0,       1,32'h14,1,32'h11,32'h0C,0);
        vecs[10] = v(0,1,32'h14,0,0,0,       1,32'h18,1,32'h11,32'h0C,0);
        vecs[11] = v(0,1,32'hDEAD,0,0,0,     0,32'h00,1,32'h11,32'h0C,0);
        vecs[12] = v(0,0,32'h0,1,0,0,        0,32'h00,1,32'h11,32'h0C,0);
        vecs[13] = v(0,0,32'h0,0,0,0,        1,32'h1C,1,32'h12,32'h10,0);
        vecs[14] = v(0,0,32'h0,1,0,0,        1,32'h1C,1,32'h12,32'h10,0);
        vecs[15] = v(0,0,32'h0,1,0,0,        1,32'h1C,1,32'h13,32'h14,0);
        vecs[16] = v(0,0,32'h0,1,0,0,        1,32'h1C,1,32'h14,32'h18,0);
        vecs[17] = v(0,0,32'h0,0,0,0,        1,32'h1C,0,32'h0,32'h0,0);
        vecs[18] = v(0,1,32'h21,0,0,0,       1,32'h1C,0,32'h0,32'h0,0);
        vecs[19] = v(0,1,32'h0,0,0,0,        1,32'h20,1,32'h21,32'h1C,0);
        vecs[20] = v(0,1,32'h55,1,0,0,       0,32'h00,1,32'h21,32'h1C,0);
        vecs[21] = v(0,0,32'h0,1,0,0,        0,32'h00,1,32'h0,32'h20,0);
        vecs[22] = v(0,0,32'h0,1,0,0,        0,32'h00,0,32'h0,32'h0,1);
        vecs[23] = v(0,0,32'h0,0,1,32'h41,   0,32'h00,0,32'h0,32'h0,1);
        vecs[24] = v(0,0,32'h0,0,0,0,        1,32'h40,0,32'h0,32'h0,0);
        vecs[25] = v(0,1,32'h77,1,0,0,       1,32'h40,0,32'h0,32'h0,0);
        vecs[26] = v(0,0,32'h0,0,0,0,        1,32'h44,1,32'h77,32'h40,0);

        for (int i = 0; i < 27; i++) begin
            runVec(vecs[i], i);
        end

        // Redirect while a slow request is pending: stale address held, word dropped.
        doReset(100);
        runVec(v(0,0,32'h0,0,0,0,          1,32'h000,0,0,0,0), 102);
        runVec(v(0,0,32'h0,0,1,32'h103,    1,32'h000,0,0,0,0), 103);
        runVec(v(0,0,32'h0,0,0,0,          1,32'h000,0,0,0,0), 104);
        runVec(v(0,1,32'hBAD,0,0,0,        1,32'h000,0,0,0,0), 105);
        runVec(v(0,0,32'h0,0,0,0,          1,32'h100,0,0,0,0), 106);
        runVec(v(0,1,32'h99,0,0,0,         1,32'h100,0,0,0,0), 107);
        runVec(v(0,0,32'h0,0,0,0,          1,32'h104,1,32'h99,32'h100,0), 108);

        // Redirect coinciding with push and pop on a two-entry buffer.
        doReset(200);
        runVec(v(0,1,32'hA1,0,0,0,         1,32'h000,0,0,0,0), 202);
        runVec(v(0,1,32'hA2,0,0,0,         1,32'h004,1,32'hA1,32'h0,0), 203);
        runVec(v(0,1,32'hA3,1,1,32'h200,   1,32'h008,1,32'hA1,32'h0,0), 204);
        runVec(v(0,0,32'h0,1,0,0,          1,32'h200,0,0,0,0), 205);
        runVec(v(0,0,32'h0,1,0,0,          1,32'h200,0,0,0,0), 206);
        runVec(v(0,1,32'hB1,1,0,0,         1,32'h200,0,0,0,0), 207);
        runVec(v(0,0,32'h0,0,0,0,          1,32'h204,1,32'hB1,32'h200,0), 208);

        // Reset lands mid-drain together with a late zero-word ack.
        doReset(300);
        runVec(v(0,1,32'hE1,0,0,0,         1,32'h000,0,0,0,0), 302);
        runVec(v(0,0,32'h0,0,1,32'h300,    1,32'h004,1,32'hE1,32'h0,0), 303);
        runVec(v(0,0,32'h0,0,0,0,          1,32'h004,0,0,0,0), 304);
        runVec(v(1,1,32'h0,0,0,0,          0,32'h000,0,0,0,0), 305);
        runVec(v(1,1,32'h0,0,1,32'h500,    0,32'h000,0,0,0,0), 306);
        runVec(v(0,0,32'h0,0,0,0,          1,32'h000,0,0,0,0), 307);
        runVec(v(0,1,32'hC1,0,0,0,         1,32'h000,0,0,0,0), 308);
        runVec(v(0,0,32'h0,0,0,0,          1,32'h004,1,32'hC1,32'h0,0), 309);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
